mult_share_arbiter: RTL and testbench

- Shares one sequential 8x8 shift-add multiply engine between NUM_REQ requesters.
- Round-robin arbitration with a per-requester valid/ready request port and one tagged response port.
- Sits between the requesting datapaths and the multiplier engine.
- Owns sequencing end to end: operand capture, iteration count, completion, and result hand-back.

---
 rtl/mult_share_arbiter_pkg.sv | 38 +++
 rtl/mult_share_arbiter_if.sv | 29 ++
 rtl/mult_share_arbiter_core.sv | 64 ++++++
 rtl/mult_share_arbiter.sv | 107 ++++++++++
 tb/tb_mult_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_pkg: shared types, default sizes and the round-robin picker
// for mult_share_arbiter. Optional build macro: MULT_SHARE_EARLY_TERM_EN.
package mult_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int MAX_REQ     = 8;
    localparam int PTR_W       = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot grant for the first valid requester at or after ptr, wrapping
    // modulo num. Vectors are sized for the largest supported requester count.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        num
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % num;
            if (i < num && !found && valid[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: request/response bundle between the requesting
// datapaths (master) and the shared multiplier arbiter (slave).
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_p;
    logic                     busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

endinterface

// File: rtl/mult_share_arbiter_core.sv
// mult_shift_add_core: sequential unsigned shift-add multiplier, one
// multiplier bit per cycle. With MULT_SHARE_EARLY_TERM_EN defined the run
// stops once no set multiplier bits remain.
module mult_shift_add_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               active;
    logic               last;

`ifdef MULT_SHARE_EARLY_TERM_EN
    // Stop when the shifted multiplier becomes zero; the count bound only
    // matters as a backstop since mplier is empty after WIDTH shifts anyway.
    assign last = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

    // done flags the iteration that completes on the coming edge.
    assign done = active && last;
    assign p    = acc;

    // Operand capture on start, then one conditional add and shift per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one shift-add multiplier among
// NUM_REQ requesters, with a single tagged response port.
// Optional build macro: MULT_SHARE_EARLY_TERM_EN (early RUN exit in the core).
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                 clk,
    input logic                 rst_n,
    mult_share_arbiter_if.slave bus
);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    tag;
    logic [ID_W-1:0]    tag_sel;
    logic [ID_W-1:0]    rr_next;
    logic [MAX_REQ-1:0] grant;
    logic               any_grant;
    logic               start;
    logic               core_done;
    logic               rsp_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] core_p;

    assign grant     = rr_pick(MAX_REQ'(bus.req_valid), PTR_W'(rr_ptr), NUM_REQ);
    assign any_grant = |grant;
    assign start     = (state == IDLE) && any_grant;
    assign rr_next   = (tag == ID_W'(NUM_REQ - 1)) ? '0 : tag + 1'b1;

    // Operand and tag mux for the granted requester.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        tag_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel   = bus.req_a[i*WIDTH +: WIDTH];
                b_sel   = bus.req_b[i*WIDTH +: WIDTH];
                tag_sel = ID_W'(i);
            end
        end
    end

    mult_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_sel),
        .b     (b_sel),
        .done  (core_done),
        .p     (core_p)
    );

    // Sequencing FSM: accept, wait for the core, hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            tag         <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        tag    <= tag_sel;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        rr_ptr      <= rr_next;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst_n so it reads zero while reset is held.
    assign bus.req_ready = (rst_n && state == IDLE) ? grant[NUM_REQ-1:0] : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = tag;
    assign bus.rsp_p     = rsp_valid_q ? core_p : '0;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench for mult_share_arbiter.
// Build with MULT_SHARE_EARLY_TERM_EN to match an early-termination DUT.
module tb_mult_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;

    int          t_idx [4] = '{0, 2, 3, 1};
    logic [7:0]  t_a   [4] = '{8'd13, 8'd255, 8'd0,   8'd7};
    logic [7:0]  t_b   [4] = '{8'd11, 8'd255, 8'd200, 8'd3};
    logic [15:0] t_p   [4] = '{16'd143, 16'hFE01, 16'd0, 16'd21};

    mult_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bus ();

    mult_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Cycles from the accept cycle to the first rsp_valid cycle.
    function automatic int exp_lat(input logic [7:0] b);
`ifdef MULT_SHARE_EARLY_TERM_EN
        int m;
        m = -1;
        for (int i = 0; i < 8; i++) if (b[i]) m = i;
        return (m < 0) ? 2 : 1 + m + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic v);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = v;
    endtask

    task automatic wait_grant(output logic [NR-1:0] g, output int at, output bit ok);
        ok = 1'b0;
        g  = '0;
        at = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.req_ready != '0) begin
                g  = bus.req_ready;
                at = cyc_cnt;
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_rsp(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.rsp_valid === 1'b1) begin
                at = cyc_cnt;
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_p !== 16'd0) begin n_err++; $display("FAIL reset_rsp_p: got %h expected 0000", bus.rsp_p); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_release: busy %b ready %b expected 0 0000", bus.busy, bus.req_ready); end
    endtask

    task automatic test_single();
        logic [NR-1:0] g;
        int t0, t1;
        bit ok;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            bus.req_valid = '0;
            bus.rsp_ready = 1'b1;
            set_req(t_idx[v], t_a[v], t_b[v], 1'b1);
            #1;
            wait_grant(g, t0, ok);
            n_vec++; if (!ok || g !== NR'(1 << t_idx[v])) begin n_err++; $display("FAIL single_grant[%0d]: got %b expected %b", v, g, NR'(1 << t_idx[v])); end
            @(negedge clk);
            set_req(t_idx[v], t_a[v], t_b[v], 1'b0);
            #1;
            n_vec++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin n_err++; $display("FAIL single_ready_pulse[%0d]: ready %b busy %b expected 0000 1", v, bus.req_ready, bus.busy); end
            wait_rsp(t1, ok);
            n_vec++; if (!ok || (t1 - t0) != exp_lat(t_b[v])) begin n_err++; $display("FAIL single_latency[%0d]: got %0d expected %0d", v, ok ? t1 - t0 : -1, exp_lat(t_b[v])); end
            n_vec++; if (bus.rsp_p !== t_p[v]) begin n_err++; $display("FAIL single_p[%0d]: got %h expected %h", v, bus.rsp_p, t_p[v]); end
            n_vec++; if (bus.rsp_id !== IW'(t_idx[v])) begin n_err++; $display("FAIL single_id[%0d]: got %0d expected %0d", v, bus.rsp_id, t_idx[v]); end
            @(negedge clk); #1;
            n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_release[%0d]: rsp_valid %b busy %b expected 0 0", v, bus.rsp_valid, bus.busy); end
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        int t0, t1, e;
        bit ok;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 8'(i + 1), 8'd2, 1'b1);
        #1;
        for (int k = 0; k < 5; k++) begin
            e = k % NR;
            wait_grant(g, t0, ok);
            n_vec++; if (!ok || g !== NR'(1 << e)) begin n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, g, NR'(1 << e)); end
            @(negedge clk);
            if (k == 4) bus.req_valid = '0;
            #1;
            wait_rsp(t1, ok);
            n_vec++; if (!ok || bus.rsp_id !== IW'(e)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, bus.rsp_id, e); end
            n_vec++; if (bus.rsp_p !== 16'(2 * (e + 1))) begin n_err++; $display("FAIL rr_p[%0d]: got %0d expected %0d", k, bus.rsp_p, 2 * (e + 1)); end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_back_pressure();
        logic [NR-1:0] g;
        int t0, t1;
        bit ok;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        set_req(0, 8'd5, 8'd6, 1'b1);
        #1;
        wait_grant(g, t0, ok);
        n_vec++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL bp_first_grant: got %b expected 0001", g); end
        @(negedge clk);
        set_req(1, 8'd9, 8'd9, 1'b1);
        #1;
        wait_rsp(t1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_rsp_timeout: got no rsp_valid expected rsp_valid within 40 cycles"); end
        for (int c = 0; c < 20; c++) begin
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'd30 || bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: valid %b p %0d id %0d ready %b expected 1 30 0 0000", c, bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req_ready);
            end
            @(negedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        wait_rsp(t1, ok);
        n_vec++; if (!ok || bus.rsp_p !== 16'd81 || bus.rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_second_rsp: p %0d id %0d expected 81 1", bus.rsp_p, bus.rsp_id); end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [NR-1:0] g;
        int t0, t1, seen;
        bit ok;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(2, 8'd10, 8'd10, 1'b1);
        #1;
        wait_grant(g, t0, ok);
        n_vec++; if (!ok || g !== 4'b0100) begin n_err++; $display("FAIL mid_grant: got %b expected 0100", g); end
        @(negedge clk);
        set_req(2, 8'd10, 8'd10, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_running: busy %b rsp_valid %b expected 1 0", bus.busy, bus.rsp_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_p !== 16'd0 || bus.req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_outputs: busy %b valid %b id %0d p %0d ready %b expected 0 0 0 0 0000", bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_stale_rsp: got %0d valid cycles expected 0", seen); end
        @(negedge clk);
        set_req(0, 8'd4, 8'd4, 1'b1);
        set_req(1, 8'd6, 8'd7, 1'b1);
        set_req(3, 8'd8, 8'd8, 1'b1);
        #1;
        wait_grant(g, t0, ok);
        n_vec++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL mid_after_grant: got %b expected 0001", g); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        wait_rsp(t1, ok);
        n_vec++; if (!ok || bus.rsp_p !== 16'd16 || bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL mid_after_rsp: p %0d id %0d expected 16 0", bus.rsp_p, bus.rsp_id); end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g;
        int t0, t1, t2;
        bit ok;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(3, 8'd3, 8'h80, 1'b1);
        #1;
        wait_grant(g, t0, ok);
        n_vec++; if (!ok || g !== 4'b1000) begin n_err++; $display("FAIL b2b_grant0: got %b expected 1000", g); end
        @(negedge clk); #1;
        wait_rsp(t1, ok);
        n_vec++; if (!ok || bus.rsp_p !== 16'h0180 || bus.rsp_id !== 2'd3) begin n_err++; $display("FAIL b2b_rsp: p %h id %0d expected 0180 3", bus.rsp_p, bus.rsp_id); end
        wait_grant(g, t2, ok);
        n_vec++; if (!ok || g !== 4'b1000 || (t2 - t0) != W + 2) begin n_err++; $display("FAIL b2b_interval: grant %b gap %0d expected 1000 %0d", g, t2 - t0, W + 2); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        wait_rsp(t1, ok);
        n_vec++; if (!ok || bus.rsp_p !== 16'h0180) begin n_err++; $display("FAIL b2b_rsp2: p %h expected 0180", bus.rsp_p); end
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
